// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and rd_data field positions
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Status bit positions in the 12-bit received word (also used by the RX FIFO)
  localparam int RXW_PERR  = 8;
  localparam int RXW_FERR  = 9;
  localparam int RXW_BRK   = 10;
  localparam int RXW_NOISE = 11;

  // Data-length encodings
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Index of the last data bit for a given length encoding (4..7)
  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    return 3'd4 + {1'b0, len};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RX line synchroniser with 3-sample majority vote
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  input  logic sample_i,
  output logic line_o,
  output logic vote_o,
  output logic noise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             samples_q;
  logic                   s0, s1, s2;

  // Metastability chain; resets to the idle (high) line level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign line_o = sync_q[SYNC_STAGES-1];

  // Holds the first two mid-bit samples; the third is the live line so the
  // vote is ready in the same cycle as the last sampling tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samples_q <= 2'b11;
    end else if (sample_i) begin
      samples_q <= {samples_q[0], line_o};
    end
  end

  assign s0 = samples_q[1];
  assign s1 = samples_q[0];
  assign s2 = line_o;

  assign vote_o  = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign noise_o = ~((s0 == s1) && (s1 == s2));

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive FSM producing status-plus-data words
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_en_i,
  input  logic        baud_tick_i,
  input  logic        rx_i,
  input  logic [1:0]  data_bits_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  input  logic        stop2_i,
  output logic [11:0] rd_data_o,
  output logic        done_flag_o,
  output logic        busy_o
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID_LO = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_MID    = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_MID_HI = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(OVERSAMPLE - 1);

  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic              stop_cnt_q;
  logic [1:0]        data_bits_q;
  logic              parity_en_q, parity_odd_q, stop2_q;
  logic [7:0]        shreg_q;
  logic              perr_q, ferr_q, noise_q, all_zero_q;
  logic [11:0]       rd_data_q;
  logic              done_q;
  logic              line_q;

  logic line, vote, sample_noise;
  logic in_frame, sample_tick, mid_tick, end_tick, fall;
  logic frame_start, emit, is_break;
  logic [11:0] word;

  assign in_frame = (state_q == RX_START) || (state_q == RX_DATA) ||
                    (state_q == RX_PARITY) || (state_q == RX_STOP);
  assign sample_tick = baud_tick_i && in_frame &&
                       ((tick_cnt_q == TICK_MID_LO) || (tick_cnt_q == TICK_MID) ||
                        (tick_cnt_q == TICK_MID_HI));
  assign mid_tick = baud_tick_i && in_frame && (tick_cnt_q == TICK_MID_HI);
  assign end_tick = baud_tick_i && (tick_cnt_q == TICK_LAST);
  assign fall     = line_q & ~line;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rx_i    (rx_i),
    .sample_i(sample_tick),
    .line_o  (line),
    .vote_o  (vote),
    .noise_o (sample_noise)
  );

  // A break is an all-zero frame up to and including stop bit 1
  assign is_break = (state_q == RX_STOP) && !stop_cnt_q && all_zero_q && !vote;

  // Word assembled from the frame flags plus the vote taken this cycle
  always_comb begin
    word = '0;
    word[RXW_NOISE] = noise_q | sample_noise;
    word[RXW_PERR]  = perr_q;
    if (is_break) begin
      word[RXW_BRK]  = 1'b1;
      word[RXW_FERR] = 1'b1;
    end else begin
      word[RXW_FERR] = ferr_q | ~vote;
      word[7:0]      = shreg_q;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and frame control strobes
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    emit        = 1'b0;
    if (!rx_en_i) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            state_d     = RX_START;
            frame_start = 1'b1;
          end
        end
        RX_START: begin
          if (mid_tick && vote) begin
            state_d = RX_IDLE;
          end else if (end_tick) begin
            state_d = RX_DATA;
          end
        end
        RX_DATA: begin
          if (end_tick && (bit_cnt_q == last_bit_idx(data_bits_q))) begin
            state_d = parity_en_q ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (end_tick) begin
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (mid_tick) begin
            if (is_break) begin
              emit    = 1'b1;
              state_d = RX_WAIT_IDLE;
            end else if (!stop2_q || stop_cnt_q) begin
              emit    = 1'b1;
              state_d = RX_IDLE;
            end
          end
        end
        RX_WAIT_IDLE: begin
          if (line) begin
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Tick/bit counters, latched frame config, shift register and frame flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      data_bits_q  <= DBITS_8;
      parity_en_q  <= 1'b0;
      parity_odd_q <= 1'b0;
      stop2_q      <= 1'b0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      noise_q      <= 1'b0;
      all_zero_q   <= 1'b1;
      line_q       <= 1'b1;
    end else begin
      line_q <= line;
      if (!in_frame) begin
        tick_cnt_q <= '0;
      end else if (baud_tick_i) begin
        tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
      end

      if (frame_start) begin
        bit_cnt_q    <= '0;
        stop_cnt_q   <= 1'b0;
        data_bits_q  <= data_bits_i;
        parity_en_q  <= parity_en_i;
        parity_odd_q <= parity_odd_i;
        stop2_q      <= stop2_i;
        shreg_q      <= '0;
        perr_q       <= 1'b0;
        ferr_q       <= 1'b0;
        noise_q      <= 1'b0;
        all_zero_q   <= 1'b1;
      end else begin
        if (mid_tick) begin
          noise_q <= noise_q | sample_noise;
        end
        case (state_q)
          RX_DATA: begin
            if (mid_tick) begin
              shreg_q[bit_cnt_q] <= vote;
              all_zero_q         <= all_zero_q & ~vote;
            end
            if (end_tick) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          RX_PARITY: begin
            if (mid_tick) begin
              perr_q     <= (^shreg_q) ^ vote ^ parity_odd_q;
              all_zero_q <= all_zero_q & ~vote;
            end
          end
          RX_STOP: begin
            if (mid_tick && !vote) begin
              ferr_q <= 1'b1;
            end
            if (end_tick) begin
              stop_cnt_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output word and single-cycle done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= emit;
      if (emit) begin
        rd_data_q <= word;
      end
    end
  end

  assign rd_data_o   = rd_data_q;
  assign done_flag_o = done_q;
  assign busy_o      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - randomized self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

  localparam int OS  = 16;
  localparam int TPC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_en = 1'b0;
  logic        baud_tick = 1'b0;
  logic        rx = 1'b1;
  logic [1:0]  data_bits = 2'b11;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic [11:0] rd_data;
  logic        done_flag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tick_div = 0;
  logic [11:0] last_word = '0;
  logic        busy_at_done = 1'b0;
  logic [11:0] prev_word = '0;

  uart_rx_deframer #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_en_i     (rx_en),
    .baud_tick_i (baud_tick),
    .rx_i        (rx),
    .data_bits_i (data_bits),
    .parity_en_i (parity_en),
    .parity_odd_i(parity_odd),
    .stop2_i     (stop2),
    .rd_data_o   (rd_data),
    .done_flag_o (done_flag),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // One-clock baud tick every TPC clocks
  always @(negedge clk) begin
    baud_tick = (tick_div == TPC - 1);
    tick_div  = (tick_div + 1) % TPC;
  end

  // Done-pulse monitor
  always @(negedge clk) begin
    if (done_flag) begin
      done_cnt     = done_cnt + 1;
      last_word    = rd_data;
      busy_at_done = busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TPC) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_ticks(OS);
  endtask

  // Sends one frame and checks it against a word computed from the framing rules.
  // exp_word < 0 means use the computed word.
  task automatic run_frame(input logic [7:0] data, input int nbits, input bit pen,
                           input bit podd, input bit pflip, input bit st1,
                           input bit s2en, input bit st2, input int glitch_bit,
                           input int exp_word, input string tag);
    logic [7:0]  m;
    logic [7:0]  dm;
    int          ones;
    bit          pbit, perr, brk, ferr;
    logic [11:0] exp;
    int          cnt0;
    m    = 8'hFF >> (8 - nbits);
    dm   = data & m;
    ones = $countones(dm);
    pbit = ((ones % 2) != int'(podd)) ^ pflip;
    perr = pen && (((ones + int'(pbit)) % 2) != int'(podd));
    brk  = (dm == 8'h00) && (!pen || !pbit) && !st1;
    ferr = brk || !st1 || (s2en && !st2);
    exp  = {glitch_bit >= 0, brk, ferr, perr, brk ? 8'h00 : dm};
    if (exp_word >= 0) exp = 12'(exp_word);

    data_bits  = 2'(nbits - 5);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2en;
    cnt0       = done_cnt;

    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        rx = data[i];
        wait_ticks(8);
        rx = ~data[i];
        wait_ticks(1);
        rx = data[i];
        wait_ticks(7);
      end else begin
        send_bit(data[i]);
      end
    end
    if (pen) send_bit(pbit);
    send_bit(st1);
    if (s2en) send_bit(st2);
    rx = 1'b1;
    wait_ticks(2 * OS);

    check({tag, "_pulses"}, done_cnt - cnt0, 1);
    check({tag, "_word"}, last_word, exp);
    check({tag, "_busy_at_done"}, busy_at_done, brk);
    prev_word = exp;
  endtask

  initial begin
    int cnt0;
    repeat (5) @(negedge clk);
    check("reset_rd_data", rd_data, 12'h000);
    check("reset_done", done_flag, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    wait_ticks(2);

    // Directed frames
    run_frame(8'hA5, 8, 0, 0, 0, 1, 0, 1, -1, 12'h0A5, "8n1_a5");
    run_frame(8'h41, 7, 1, 0, 1, 1, 0, 1, -1, 12'h141, "7e1_perr");
    run_frame(8'h15, 5, 1, 1, 0, 1, 1, 0, -1, 12'h215, "5o2_ferr");

    // Break: line low for 20 bit times, 8E1
    data_bits  = 2'b11;
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    cnt0 = done_cnt;
    rx = 1'b0;
    wait_ticks(20 * OS);
    check("brk_pulses", done_cnt - cnt0, 1);
    check("brk_word", last_word, 12'h600);
    check("brk_busy_held", busy, 1'b1);
    rx = 1'b1;
    wait_ticks(2 * OS);
    check("brk_no_more_pulses", done_cnt - cnt0, 1);
    check("brk_idle_after_high", busy, 1'b0);
    run_frame(8'h3C, 8, 0, 0, 0, 1, 0, 1, -1, 12'h03C, "after_brk");

    // Short low glitch in idle
    cnt0 = done_cnt;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(OS);
    check("glitch_idle_busy", busy, 1'b0);
    wait_ticks(OS);
    check("glitch_no_pulse", done_cnt - cnt0, 0);

    // One disagreeing sample inside data bit 2
    run_frame(8'h3C, 8, 0, 0, 0, 1, 0, 1, 2, -1, "noise");

    // Receiver disabled after data bit 3
    data_bits = 2'b11;
    parity_en = 1'b0;
    stop2     = 1'b0;
    cnt0 = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(cnt0[0] ^ (i % 2 == 0));
    rx_en = 1'b0;
    wait_ticks(1);
    check("rxen_busy", busy, 1'b0);
    for (int i = 4; i < 8; i++) send_bit(i % 2 == 0);
    send_bit(1'b1);
    wait_ticks(OS);
    check("rxen_no_pulse", done_cnt - cnt0, 0);
    check("rxen_rd_data_held", rd_data, prev_word);
    rx_en = 1'b1;
    wait_ticks(2);

    // Reset pulsed mid-frame while the line is high (data 0xFF)
    cnt0 = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    wait_ticks(4);
    rst_n = 1'b0;
    #2;
    check("rst_mid_rd_data", rd_data, 12'h000);
    check("rst_mid_done", done_flag, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(6 * OS);
    check("rst_no_pulse", done_cnt - cnt0, 0);
    check("rst_busy_idle", busy, 1'b0);
    run_frame(8'h5A, 8, 0, 0, 0, 1, 0, 1, -1, 12'h05A, "after_rst");

    // Randomized frames
    for (int k = 0; k < 20; k++) begin
      int         nb;
      logic [7:0] d;
      bit         pen, podd, pflip, st1, s2en, st2;
      nb    = 5 + $urandom_range(0, 3);
      d     = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      pflip = ($urandom_range(0, 3) == 0);
      st1   = ($urandom_range(0, 4) != 0);
      s2en  = 1'($urandom_range(0, 1));
      st2   = ($urandom_range(0, 4) != 0);
      run_frame(d, nb, pen, podd, pflip, st1, s2en, st2, -1, -1, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
